// File: rtl/ppu_pkg.sv
// Shared types and constants for the background render scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppu_pkg;

    localparam int LINE_PIXELS_DEF = 512;
    localparam int PIPE_DEPTH_DEF  = 3;
    localparam int H_TRIGGER_DEF   = 1040;

    localparam logic [1:0] HOST_SEL_CHAR     = 2'd0;
    localparam logic [1:0] HOST_SEL_CHARDATA = 2'd1;
    localparam logic [1:0] HOST_SEL_PAL      = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RENDER = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HOST   = 2'd3
    } state_t;

    // One-hot {pal, chardata, char}; the reserved target writes nothing.
    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        oh = 3'b000;
        case (sel)
            HOST_SEL_CHAR:     oh = 3'b001;
            HOST_SEL_CHARDATA: oh = 3'b010;
            HOST_SEL_PAL:      oh = 3'b100;
            default:           oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ppu_render_sched_if.sv
// Host write bus into the glyph/glyph-data/palette RAMs and the granted write port.
// Latency: n/a (wiring only).
// Backpressure: host_req held until host_ack pulses; master is the host, slave the scheduler.
interface ppu_render_sched_if #(
    parameter int VRAM_AW = 12
);
    logic               host_req;
    logic [1:0]         host_sel;
    logic [VRAM_AW-1:0] host_addr;
    logic [15:0]        host_wdata;
    logic               host_ack;
    logic [2:0]         vram_we;
    logic [VRAM_AW-1:0] vram_addr;
    logic [15:0]        vram_wdata;

    modport master (
        output host_req, host_sel, host_addr, host_wdata,
        input  host_ack, vram_we, vram_addr, vram_wdata
    );

    modport slave (
        input  host_req, host_sel, host_addr, host_wdata,
        output host_ack, vram_we, vram_addr, vram_wdata
    );
endinterface

// File: rtl/ppu_render_sched_pipe_delay.sv
// Fixed-depth register delay line (din -> dout).
// Latency: DEPTH cycles; dout is taken straight from the last register.
// Backpressure: none, advances every cycle.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/ppu_render_sched.sv
// Render pass sequencer sharing the VRAMs with a host write port.
// Latency: RENDER starts 1 cycle after trigger; lb_we/lb_addr trail src_valid/src_cnt by PIPE_DEPTH.
// Backpressure: host_req is held off (no ack) while a pass or its drain is in flight.
// Ports: vga_clk/rst_n; counter_x/counter_y VGA position; host (slave modport) host
// write request and vram write port; src_valid/src_cnt fetch pipeline index;
// lb_we/lb_addr line-buffer write; busy; overrun (sticky trigger-while-rendering).
module ppu_render_sched
    import ppu_pkg::*;
#(
    parameter int LINE_PIXELS = LINE_PIXELS_DEF,
    parameter int PIPE_DEPTH  = PIPE_DEPTH_DEF,
    parameter int H_TRIGGER   = H_TRIGGER_DEF,
    parameter int VRAM_AW     = 12
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic [10:0]       counter_x,
    input  logic [9:0]        counter_y,
    ppu_render_sched_if.slave host,
    output logic              src_valid,
    output logic [8:0]        src_cnt,
    output logic              lb_we,
    output logic [9:0]        lb_addr,
    output logic              busy,
    output logic              overrun
);
    localparam int               DCW        = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [8:0]       SRC_LAST   = 9'(LINE_PIXELS - 1);
    localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(PIPE_DEPTH - 1);

    state_t         state;
    logic           bank;
    logic [DCW-1:0] drain_cnt;
    logic           trig;
    logic           start;
    logic           grant;
    logic           unused_y_bits;
    logic [10:0]    lb_dat;

    // Only the low two line bits matter: bit0 picks the line pair, bit1 the bank.
    assign unused_y_bits = ^counter_y[9:2];

    assign trig  = (counter_x == 11'(H_TRIGGER)) && !counter_y[0];
    // A trigger seen during the host cycle is held as pending by jumping
    // straight into RENDER, so the IDLE cycle is skipped.
    assign start = trig && ((state == ST_IDLE) || (state == ST_HOST));
    assign grant = host.host_req && (state == ST_IDLE) && !trig;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            src_valid       <= 1'b0;
            src_cnt         <= '0;
            bank            <= 1'b0;
            drain_cnt       <= '0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
            host.host_ack   <= 1'b0;
            host.vram_we    <= 3'b000;
            host.vram_addr  <= '0;
            host.vram_wdata <= '0;
        end else begin
            host.host_ack <= grant;
            host.vram_we  <= grant ? sel_onehot(host.host_sel) : 3'b000;
            if (grant) begin
                host.vram_addr  <= VRAM_AW'(host.host_addr);
                host.vram_wdata <= host.host_wdata;
            end

            if (trig && ((state == ST_RENDER) || (state == ST_DRAIN)))
                overrun <= 1'b1;

            case (state)
                ST_IDLE, ST_HOST: begin
                    if (start) begin
                        state     <= ST_RENDER;
                        src_cnt   <= '0;
                        src_valid <= 1'b1;
                        bank      <= counter_y[1];
                        busy      <= 1'b1;
                    end else if (grant) begin
                        state <= ST_HOST;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_RENDER: begin
                    // Wraps to 0 on the last pixel so src_cnt idles at 0.
                    src_cnt <= src_cnt + 9'd1;
                    if (src_cnt == SRC_LAST) begin
                        state     <= ST_DRAIN;
                        src_valid <= 1'b0;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bank rides along the delay line so lb_addr comes straight off registers.
    pipe_delay #(
        .WIDTH (11),
        .DEPTH (PIPE_DEPTH)
    ) u_lb_delay (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .din     ({src_valid, bank, src_cnt}),
        .dout    (lb_dat)
    );

    assign lb_we   = lb_dat[10];
    assign lb_addr = lb_dat[9:0];
endmodule

// File: tb/tb_ppu_render_sched.sv
// Bench for ppu_render_sched: directed steps then random triggers/host writes,
// compared every cycle against a pass-offset model of the scheduler.
module tb_ppu_render_sched;
    localparam int LP = 512;
    localparam int PD = 3;
    localparam int HT = 1040;

    logic        vga_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [10:0] counter_x = '0;
    logic [9:0]  counter_y = '0;
    logic        src_valid;
    logic [8:0]  src_cnt;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic        busy;
    logic        overrun;

    ppu_render_sched_if #(.VRAM_AW(12)) hif ();

    ppu_render_sched #(
        .LINE_PIXELS (LP),
        .PIPE_DEPTH  (PD),
        .H_TRIGGER   (HT),
        .VRAM_AW     (12)
    ) dut (
        .vga_clk   (vga_clk),
        .rst_n     (rst_n),
        .counter_x (counter_x),
        .counter_y (counter_y),
        .host      (hif),
        .src_valid (src_valid),
        .src_cnt   (src_cnt),
        .lb_we     (lb_we),
        .lb_addr   (lb_addr),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 vga_clk = ~vga_clk;

    // Model: mk = cycles since the first src_valid cycle of the current pass
    // (-1 when no pass); m_ack marks the single host-write cycle.
    int          mk = -1;
    bit          m_ack = 0;
    bit          m_ovr = 0;
    bit          m_bank = 0;
    logic [2:0]  m_we = 3'b000;
    logic [11:0] m_addr = '0;
    logic [15:0] m_data = '0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0;
    int cnt_valid = 0, cnt_lbwe = 0, cnt_busy = 0;
    int last_lbwe = 0, ack_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mk = -1; m_ack = 0; m_ovr = 0; m_bank = 0;
        m_we = 3'b000; m_addr = '0; m_data = '0;
    endtask

    task automatic check_all();
        bit exp_valid, exp_we, exp_busy;
        exp_valid = (mk >= 0) && (mk < LP);
        exp_we    = (mk >= PD) && (mk < LP + PD);
        exp_busy  = (mk >= 0) || m_ack;
        chk("src_valid", src_valid, exp_valid);
        chk("src_cnt", src_cnt, exp_valid ? mk : 0);
        chk("lb_we", lb_we, exp_we);
        if (exp_we) chk("lb_addr", lb_addr, {m_bank, 9'(mk - PD)});
        chk("busy", busy, exp_busy);
        chk("host_ack", hif.host_ack, m_ack);
        chk("vram_we", hif.vram_we, m_ack ? m_we : 3'b000);
        chk("vram_addr", hif.vram_addr, m_addr);
        chk("vram_wdata", hif.vram_wdata, m_data);
        chk("overrun", overrun, m_ovr);
        if (src_valid === 1'b1) cnt_valid++;
        if (lb_we === 1'b1) begin cnt_lbwe++; last_lbwe = cyc; end
        if (busy === 1'b1) cnt_busy++;
        if (hif.host_ack === 1'b1) ack_cyc = cyc;
    endtask

    // Advance one clock: step the model from the inputs driven now, then
    // sample the DUT 1 ns after the edge.
    task automatic tick();
        bit trig;
        trig = (counter_x == 11'(HT)) && !counter_y[0];
        if (mk >= 0) begin
            if (trig) m_ovr = 1;
            mk = (mk + 1 == LP + PD) ? -1 : mk + 1;
            m_ack = 0;
        end else if (trig) begin
            mk = 0; m_bank = counter_y[1]; m_ack = 0;
        end else if (hif.host_req && !m_ack) begin
            m_ack  = 1;
            m_we   = (hif.host_sel == 2'd3) ? 3'b000 : 3'(1 << hif.host_sel);
            m_addr = hif.host_addr;
            m_data = hif.host_wdata;
        end else begin
            m_ack = 0;
        end
        @(posedge vga_clk);
        #1;
        cyc++;
        check_all();
        if (m_ack) hif.host_req = 1'b0;
        counter_x = '0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic trig_at(input int y);
        counter_x = 11'(HT);
        counter_y = 10'(y);
        tick();
    endtask

    task automatic host_wr(input logic [1:0] sel, input logic [11:0] addr, input logic [15:0] data);
        hif.host_req   = 1'b1;
        hif.host_sel   = sel;
        hif.host_addr  = addr;
        hif.host_wdata = data;
    endtask

    task automatic clear_counts();
        cnt_valid = 0; cnt_lbwe = 0; cnt_busy = 0;
    endtask

    initial begin
        hif.host_req   = 1'b0;
        hif.host_sel   = 2'd0;
        hif.host_addr  = '0;
        hif.host_wdata = '0;

        // Reset state
        #12;
        check_all();
        chk("lb_addr_reset", lb_addr, 10'h000);
        @(negedge vga_clk);
        rst_n = 1'b1;
        run(3);

        // Bank 0 pass
        clear_counts();
        trig_at(4);
        run(520);
        chk("pass0_valid_cycles", cnt_valid, LP);
        chk("pass0_lbwe_cycles", cnt_lbwe, LP);
        chk("pass0_busy_cycles", cnt_busy, LP + PD);

        // Bank 1 pass
        clear_counts();
        trig_at(6);
        run(520);
        chk("pass1_lbwe_cycles", cnt_lbwe, LP);

        // Odd line: no pass
        clear_counts();
        trig_at(5);
        run(10);
        chk("odd_line_busy", cnt_busy, 0);

        // Host write while idle
        host_wr(2'd2, 12'h155, 16'hBEEF);
        run(4);
        chk("host_pal_ack_seen", ack_cyc, cyc - 3);

        // Contention: host request 10 cycles into a pass
        trig_at(8);
        run(10);
        host_wr(2'd1, 12'h0A5, 16'h1234);
        run(520);
        chk("ack_after_last_lbwe", ack_cyc - last_lbwe, 2);

        // Trigger in the host cycle
        host_wr(2'd0, 12'h7FF, 16'h00C3);
        tick();
        chk("in_host_cycle", hif.host_ack, 1'b1);
        counter_x = 11'(HT);
        counter_y = 10'd10;
        tick();
        clear_counts();
        run(520);
        chk("host_trig_lbwe_cycles", cnt_lbwe, LP);

        // Overrun: second trigger at cycle 100 of a pass
        clear_counts();
        trig_at(12);
        run(99);
        counter_x = 11'(HT);
        counter_y = 10'd12;
        tick();
        run(420);
        chk("overrun_valid_cycles", cnt_valid, LP);
        chk("overrun_sticky", overrun, 1'b1);

        // Random triggers and host writes
        for (int i = 0; i < 3000; i++) begin
            counter_x = ($urandom_range(0, 199) == 0) ? 11'(HT) : 11'($urandom_range(0, 1039));
            counter_y = 10'($urandom_range(0, 1023));
            if (!hif.host_req && ($urandom_range(0, 15) == 0))
                host_wr(2'($urandom_range(0, 3)), 12'($urandom), 16'($urandom));
            tick();
        end
        hif.host_req = 1'b0;
        run(530);

        // Reset in the middle of a pass
        trig_at(14);
        run(50);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("lb_addr_midreset", lb_addr, 10'h000);
        @(negedge vga_clk);
        rst_n = 1'b1;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
